// File: rtl/mem_defs.sv
// Shared definitions for the data-memory responder: FSM encoding,
// default access latency and the byte-to-word address offset.
package mem_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_LATENCY = 4;
  localparam int WORD_OFFSET     = 2;

  function automatic logic is_aligned(input logic [1:0] byte_offset);
    return (byte_offset == 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with write enable and registered read.
// Contents are intentionally not reset.
module data_mem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // The read register only moves on reads, so it keeps the last read word across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the data-memory request interface: accepts one request,
// counts out a fixed latency, then pulses oReady with read data / fault.
module data_mem_responder
  import mem_defs::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic        iRW,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic        oReady,
  output logic [31:0] oData,
  output logic        oFault
);

  localparam int AW = ADDR_WIDTH + WORD_OFFSET;

  state_t          state, next_state;
  logic [3:0]      cnt;
  logic            req_rw;
  logic [AW-1:0]   req_addr;
  logic [31:0]     req_data;
  logic            accept, enter_done;
  logic            acc_rw;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     acc_data;
  logic            acc_aligned;
  logic            ram_en;
  logic [31:0]     ram_q;
  logic            rd_valid;
  logic            ready, fault;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^iAddr[31:AW];

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (iValid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            next_state = S_DONE;
            enter_done = 1'b1;
          end else begin
            next_state = S_WAIT;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          next_state = S_DONE;
          enter_done = 1'b1;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // With LATENCY=1 the access happens on the accept edge, before the request registers load.
  assign acc_rw      = (state == S_IDLE) ? iRW          : req_rw;
  assign acc_addr    = (state == S_IDLE) ? iAddr[AW-1:0] : req_addr;
  assign acc_data    = (state == S_IDLE) ? iData        : req_data;
  assign acc_aligned = is_aligned(acc_addr[1:0]);
  assign ram_en      = enter_done & acc_aligned & ~iRst;

  data_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (iClk),
    .en    (ram_en),
    .we    (acc_rw),
    .addr  (acc_addr[AW-1:WORD_OFFSET]),
    .wdata (acc_data),
    .rdata (ram_q)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_rw   <= 1'b0;
      req_addr <= '0;
      req_data <= 32'd0;
      ready    <= 1'b0;
      fault    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state <= next_state;
      ready <= enter_done;
      if (accept) begin
        req_rw   <= iRW;
        req_addr <= iAddr[AW-1:0];
        req_data <= iData;
        cnt      <= 4'(LATENCY - 1);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // rd_valid selects the RAM read register onto oData; aligned writes leave it alone.
      if (enter_done) begin
        fault <= ~acc_aligned;
        if (!acc_aligned) begin
          rd_valid <= 1'b0;
        end else if (!acc_rw) begin
          rd_valid <= 1'b1;
        end
      end else begin
        fault <= 1'b0;
      end
    end
  end

  assign oReady = ready;
  assign oFault = fault;
  assign oData  = rd_valid ? ram_q : 32'd0;

endmodule
